// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write port of the boot loader.
// master: the loader side; slave: the byte source / IMEM side.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid pulses for one cycle after the fourth byte of a word.
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        lane_full,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [31:0] shreg;

    // Current byte completes a word.
    assign lane_full = (cnt == 2'(BYTES_PER_WORD - 1));

    // Shift bytes in from the top so the first byte ends up in the low lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_valid) begin
                shreg <= {byte_in, shreg[31:8]};
                if (lane_full) begin
                    word       <= {byte_in, shreg[31:8]};
                    word_valid <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: SYNC, LEN, 4*LEN payload bytes, XOR CSUM.
// Writes words sequentially into IMEM and releases the CPU only after a
// checksum-valid image has been loaded.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_boot_loader_if.master     bus,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);

    state_t            state;
    logic [7:0]        len_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              lane_full;
    logic              wa_valid;
    logic [31:0]       wa_word;
    logic              last_word;

    // Ready in every state except DONE, and never while reset is held.
    assign bus.rx_ready = ~reset && (state != ST_DONE);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign last_word    = ((32'(widx) + 32'd1) == 32'(len_q));

    // The assembler's registered pulse and word drive the IMEM port directly,
    // so the write lands in the cycle right after the fourth byte.
    assign bus.imem_we   = wa_valid;
    assign bus.imem_wd   = wa_word;
    assign bus.imem_addr = addr_q;

    imem_boot_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept && (state == ST_LEN)),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_in    (bus.rx_data),
        .lane_full  (lane_full),
        .word_valid (wa_valid),
        .word       (wa_word)
    );

    // Frame parser, checksum, word address counter and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            csum_q    <= '0;
            widx      <= '0;
            addr_q    <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) state <= ST_LEN;
                end
                ST_LEN: begin
                    if (bus.rx_data == 8'h00 || 32'(bus.rx_data) > IMEM_WORDS) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end else begin
                        len_q  <= bus.rx_data;
                        widx   <= '0;
                        csum_q <= '0;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_q <= csum_q ^ bus.rx_data;
                    if (lane_full) begin
                        addr_q <= widx;
                        // Index stays on the last word so it never passes IMEM_WORDS-1.
                        if (last_word) state <= ST_CSUM;
                        else           widx  <= widx + ADDR_W'(1);
                    end
                end
                ST_CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        error <= 1'b0;
                        state <= ST_LEN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames built from random payloads,
// expected IMEM writes and checksums derived from the frame format.
module tb_imem_boot_loader;

    localparam int unsigned IMEM_WORDS = 64;
    localparam int unsigned ADDR_W     = 6;

    logic clk;
    logic reset;
    logic cpu_reset;
    logic done;
    logic error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pl[$];      // payload bytes of the frame under construction
    logic [39:0] exp_w[$];   // expected writes {addr, word}
    logic [39:0] cap_w[$];   // observed writes {addr, word}
    int          double_we = 0;
    logic        prev_we   = 1'b0;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            cap_w.push_back({8'(bus.imem_addr), bus.imem_wd});
            if (prev_we) double_we++;
        end
        prev_we = (bus.imem_we === 1'b1);
    end

    // ---------------- stimulus helpers and reference model ----------------

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got %b want 1", bus.rx_ready);
        end
        @(posedge clk);
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cap_w.delete();
        exp_w.delete();
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
    endtask

    // Word k is payload bytes 4k..4k+3, LSB first, written to address k.
    task automatic model_frame();
        for (int k = 0; k < pl.size() / 4; k++)
            exp_w.push_back({8'(k), pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]});
    endtask

    function automatic logic [7:0] csum_of();
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] n, input logic [7:0] cs, input int max_gap);
        send_byte(8'hA5, 0);
        send_byte(n, 0);
        foreach (pl[i]) send_byte(pl[i], $urandom_range(0, max_gap));
        send_byte(cs, 0);
        end_stream();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wd, cpu_reset, done, error}
            !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0d wd=%h cpu_reset=%b done=%b error=%b want 0 0 0 0 1 0 0",
                     bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wd, cpu_reset, done, error);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", bus.rx_ready);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] fr[7];
        do_reset();
        fr = '{8'hA5, 8'h01, 8'h04, 8'h30, 8'hA0, 8'hE3, 8'h77};
        for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
        #1;
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wd} !== {1'b1, 6'd0, 32'hE3A03004}) begin
            errors++;
            $display("FAIL single_write: got we=%b addr=%0d wd=%h want 1 0 e3a03004",
                     bus.imem_we, bus.imem_addr, bus.imem_wd);
        end
        checks++;
        if ({done, cpu_reset} !== 2'b01) begin
            errors++;
            $display("FAIL single_pre_csum: got done=%b cpu_reset=%b want 0 1", done, cpu_reset);
        end
        send_byte(fr[6], 0);
        #1;
        checks++;
        if ({done, cpu_reset, error, bus.rx_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL single_done: got done=%b cpu_reset=%b error=%b rdy=%b want 1 0 0 0",
                     done, cpu_reset, error, bus.rx_ready);
        end
        // Further input in DONE must be ignored.
        repeat (5) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hA5;
        end
        end_stream();
        repeat (2) @(negedge clk);
        checks++;
        if (cap_w.size() != 1 || done !== 1'b1 || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ignores_input: got writes=%0d done=%b rdy=%b want 1 1 0",
                     cap_w.size(), done, bus.rx_ready);
        end
    endtask

    task automatic test_max_length();
        do_reset();
        pl.delete();
        for (int k = 0; k < IMEM_WORDS; k++) repeat (4) pl.push_back(8'(k));
        model_frame();
        send_frame(8'(IMEM_WORDS), csum_of(), 0);
        checks++;
        if (cap_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL max_len_count: got %0d want %0d", cap_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
            checks++;
            if (cap_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL max_len_write[%0d]: got %h want %h", i, cap_w[i], exp_w[i]);
            end
        end
        checks++;
        if ({done, cpu_reset, error} !== 3'b100) begin
            errors++;
            $display("FAIL max_len_status: got done=%b cpu_reset=%b error=%b want 1 0 0", done, cpu_reset, error);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        pl = '{8'h04, 8'h30, 8'hA0, 8'hE3};
        model_frame();
        send_frame(8'h01, 8'h76, 0);
        checks++;
        if ({error, cpu_reset, done} !== 3'b110) begin
            errors++;
            $display("FAIL bad_csum_status: got error=%b cpu_reset=%b done=%b want 1 1 0", error, cpu_reset, done);
        end
        rand_payload(3);
        model_frame();
        send_frame(8'd3, csum_of(), 1);
        checks++;
        if ({error, cpu_reset, done} !== 3'b001) begin
            errors++;
            $display("FAIL recover_status: got error=%b cpu_reset=%b done=%b want 0 0 1", error, cpu_reset, done);
        end
        checks++;
        if (cap_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL recover_count: got %0d want %0d", cap_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
            checks++;
            if (cap_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL recover_write[%0d]: got %h want %h", i, cap_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2];
        lens = '{8'd0, 8'(IMEM_WORDS + 1)};
        foreach (lens[j]) begin
            do_reset();
            send_byte(8'hA5, 0);
            send_byte(lens[j], 0);
            // Trailing bytes that would be payload must not produce writes.
            for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 8'hA4)), 0);
            end_stream();
            repeat (2) @(negedge clk);
            checks++;
            if ({error, cpu_reset, done} !== 3'b110 || cap_w.size() != 0) begin
                errors++;
                $display("FAIL bad_len_%0d: got error=%b cpu_reset=%b done=%b writes=%0d want 1 1 0 0",
                         lens[j], error, cpu_reset, done, cap_w.size());
            end
        end
    endtask

    task automatic test_noise();
        int n;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            send_byte(8'h00, 0);
            send_byte(8'h5A, 0);
            n = $urandom_range(2, 8);
            rand_payload(n);
            pl[$urandom_range(0, 4 * n - 1)] = 8'hA5;
            model_frame();
            send_frame(8'(n), csum_of(), 3);
            checks++;
            if ({done, cpu_reset, error} !== 3'b100) begin
                errors++;
                $display("FAIL noise_status[%0d]: got done=%b cpu_reset=%b error=%b want 1 0 0",
                         rep, done, cpu_reset, error);
            end
            checks++;
            if (cap_w.size() != exp_w.size()) begin
                errors++;
                $display("FAIL noise_count[%0d]: got %0d want %0d", rep, cap_w.size(), exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
                checks++;
                if (cap_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL noise_write[%0d][%0d]: got %h want %h", rep, i, cap_w[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        rand_payload(3);
        pl[3] = 8'hFF;   // keeps word 0 non-zero so the wd clear is visible
        send_byte(8'hA5, 0);
        send_byte(8'd3, 0);
        for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
        checks++;
        if (cap_w.size() != 1 || cap_w[0] !== {8'd0, pl[3], pl[2], pl[1], pl[0]}) begin
            errors++;
            $display("FAIL mid_load_first_word: got n=%0d w=%h want 1 %h",
                     cap_w.size(), cap_w.size() > 0 ? cap_w[0] : 40'h0, {8'd0, pl[3], pl[2], pl[1], pl[0]});
        end
        #2;
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wd, cpu_reset, done, error}
            !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_load_reset: got rdy=%b we=%b addr=%0d wd=%h cpu_reset=%b done=%b error=%b want 0 0 0 0 1 0 0",
                     bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wd, cpu_reset, done, error);
        end
        @(negedge clk);
        reset = 1'b0;
        cap_w.delete();
        exp_w.delete();
        rand_payload(2);
        model_frame();
        send_frame(8'd2, csum_of(), 0);
        checks++;
        if (cap_w.size() != 2 || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_status: got writes=%0d done=%b want 2 1", cap_w.size(), done);
        end
        for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
            checks++;
            if (cap_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL reload_write[%0d]: got %h want %h", i, cap_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (double_we != 0) begin
            errors++;
            $display("FAIL we_back_to_back: got %0d double pulses want 0", double_we);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_single_word();
        test_max_length();
        test_bad_csum();
        test_bad_len();
        test_noise();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
